aggregate_seq: RTL
==================

// Module: aggregate_seq
// PURPOSE
//  Sequential, parametrised GCN neighbour aggregation: out[r][f] = sum_i A'[r][i] * X[i][f].
//  A' = adj_mat, optionally with forced self-loops. X = transformed feature matrix.
//  Walks one neighbour per cycle with all features in parallel (1 adder per feature).
//  Streams one output row per valid/ready handshake, with that row's degree.
//  Sits between the COO->dense adjacency builder and the transform stage and the activation/next layer.
// PARAMETERS
//  NUM_NODES  6   nodes (rows/cols of adj_mat, rows of feat_mat), >=2
//  NUM_FEAT   3   features per node (cols of feat_mat)
//  DATA_W     16  unsigned feature width
//  ACC_W      DATA_W+$clog2(NUM_NODES+1)  output width; derived, never overflows
//  DEG_W      $clog2(NUM_NODES+1)         degree width; derived
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  start      in   1                  begin a pass; accepted only in IDLE
//  self_loop  in   1                  1: treat A'[r][r]=1; latched at start accept
//  adj_mat    in   [NUM_NODES-1:0] x NUM_NODES   row r bit i = edge r<-i
//  feat_mat   in   [DATA_W-1:0] x NUM_NODES x NUM_FEAT  transformed features
//  busy       out  1                  high from start accept until DONE exits
//  out_valid  out  1                  out_row/out_data/out_deg valid
//  out_ready  in   1                  consumer accepts row when out_valid&out_ready
//  out_row    out  $clog2(NUM_NODES)  index of emitted row
//  out_data   out  [ACC_W-1:0] x NUM_FEAT  aggregated row
//  out_deg    out  DEG_W              count of ones in A' row (incl. forced self-loop)
//  done       out  1                  one-cycle pulse after last row accepted
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, out_valid, done=0; out_row, out_data, out_deg,
//   row and nbr counters=0; latched self_loop=0. Reset mid-pass aborts the pass and emits no rows.
//  FSM: IDLE -> ACC -> EMIT -> (ACC | DONE) -> IDLE.
//   IDLE: when start=1, clear accumulators, set row=0 and nbr=0, latch self_loop, go to ACC.
//   ACC: each cycle, if A'[row][nbr]: acc[f]+=feat_mat[nbr][f] for all f, and deg+=1.
//    nbr increments each cycle. After nbr=NUM_NODES-1 goes to EMIT.
//    ACC lasts exactly NUM_NODES cycles per row.
//   EMIT: out_valid=1, and out_row, out_data, out_deg are held stable until the handshake.
//    On out_valid&out_ready: drop out_valid.
//     If row<NUM_NODES-1: row+=1, nbr=0, clear acc/deg, go to ACC.
//     Otherwise go to DONE. Backpressure may stall EMIT indefinitely.
//   DONE: done=1 for exactly one cycle, busy=0 on exit, go to IDLE.
//  Timing: out_valid rises NUM_NODES cycles after the start-accept edge.
//   With out_ready tied high, each row takes NUM_NODES+1 cycles.
//   done pulses NUM_NODES*(NUM_NODES+1)+1 cycles after start accept.
//  start while busy=1 is ignored and not queued. start in the same cycle as done is ignored.
//   The pass after that needs a fresh start in IDLE.
//  adj_mat and feat_mat are not latched. The upstream block holds them stable while busy=1.
//  Arithmetic: unsigned, zero-extended to ACC_W; no saturation needed.
//  Row of all zeros with self_loop=0: out_data=0, out_deg=0, still emitted.
//  Rows are emitted in ascending order 0..NUM_NODES-1, each exactly once per pass.
// TESTING
//  Defaults. adj=identity, self_loop=0, feat[i][f]=10*i+f, ready=1 -> row r data=feat[r], deg=1.
//   out_valid first high 6 cycles after start; done 43 cycles after start.
//  adj all ones, feat all 16'hFFFF, self_loop=1 -> every row data=6*65535=393210, deg=6.
//   No overflow in ACC_W=19.
//  adj all zeros, self_loop=1, feat[i][f]=i+1 -> row r data=r+1 per feature, deg=1.
//   Same stimulus with self_loop=0 -> data=0, deg=0.
//  Backpressure: hold out_ready=0 for 5 cycles on row 2, then release.
//   Row 2 stays stable during the stall; out_row sequence is exactly 0..5; done is late by 5 cycles.
//  Assert rst for 1 cycle during row 3 ACC -> out_valid=0 and busy=0 immediately.
//   A new start then gives a full 6-row pass starting at row 0.
//  start pulses during busy and on the done cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/aggregate_seq.sv
// Sequential GCN neighbour aggregation: out[r][f] = sum_i A'[r][i] * X[i][f].
// Walks one neighbour per cycle with all features in parallel, then streams the row out.
module aggregate_seq #(
    parameter int unsigned NUM_NODES = 6,
    parameter int unsigned NUM_FEAT  = 3,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = DATA_W + $clog2(NUM_NODES + 1),
    parameter int unsigned DEG_W     = $clog2(NUM_NODES + 1)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic                                             self_loop,
    input  logic [NUM_NODES-1:0][NUM_NODES-1:0]              adj_mat,
    input  logic [NUM_NODES-1:0][NUM_FEAT-1:0][DATA_W-1:0]   feat_mat,
    output logic                                             busy,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [$clog2(NUM_NODES)-1:0]                     out_row,
    output logic [NUM_FEAT-1:0][ACC_W-1:0]                   out_data,
    output logic [DEG_W-1:0]                                 out_deg,
    output logic                                             done
);

    localparam int unsigned IdxW = $clog2(NUM_NODES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NODES - 1);

    typedef enum logic [1:0] {StIdle, StAcc, StEmit, StDone} state_e;

    state_e                        state_q, state_d;
    logic [IdxW-1:0]               row_q, row_d;
    logic [IdxW-1:0]               nbr_q, nbr_d;
    logic [NUM_FEAT-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [DEG_W-1:0]              deg_q, deg_d;
    logic                          sl_q, sl_d;
    logic                          done_q;
    logic                          edge_bit;

    // Effective adjacency bit A'[row][nbr], including the latched forced self-loop.
    assign edge_bit = adj_mat[row_q][nbr_q] | (sl_q & (row_q == nbr_q));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        nbr_d   = nbr_q;
        acc_d   = acc_q;
        deg_d   = deg_q;
        sl_d    = sl_q;
        unique case (state_q)
            StIdle: begin
                // The cycle carrying the done pulse still counts as busy; start is dropped.
                if (start && !done_q) begin
                    acc_d   = '0;
                    deg_d   = '0;
                    row_d   = '0;
                    nbr_d   = '0;
                    sl_d    = self_loop;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (edge_bit) begin
                    for (int f = 0; f < int'(NUM_FEAT); f++) begin
                        acc_d[f] = acc_q[f] + ACC_W'(feat_mat[nbr_q][f]);
                    end
                    deg_d = deg_q + DEG_W'(1);
                end
                if (nbr_q == LastIdx) begin
                    nbr_d   = '0;
                    state_d = StEmit;
                end else begin
                    nbr_d = nbr_q + IdxW'(1);
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (row_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + IdxW'(1);
                        acc_d   = '0;
                        deg_d   = '0;
                        state_d = StAcc;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            nbr_q   <= '0;
            acc_q   <= '0;
            deg_q   <= '0;
            sl_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            nbr_q   <= nbr_d;
            acc_q   <= acc_d;
            deg_q   <= deg_d;
            sl_q    <= sl_d;
            done_q  <= (state_q == StDone);
        end
    end

    assign busy      = (state_q != StIdle) | done_q;
    assign out_valid = (state_q == StEmit);
    assign out_row   = row_q;
    assign out_data  = acc_q;
    assign out_deg   = deg_q;
    assign done      = done_q;

endmodule
